// File: rtl/batch_out_fifo_pkg.sv
// Shared definitions for the batch filter output path.
// Holds the filter result width and the offset-binary to two's complement
// conversion used wherever filter results are re-interpreted as signed.
package BatchOut_p;

  localparam int unsigned OUT_WIDTH = 12;

  // Offset binary -> two's complement: flipping the MSB re-centres the code.
  function automatic logic [OUT_WIDTH-1:0] offset_to_signed(input logic [OUT_WIDTH-1:0] x);
    return {~x[OUT_WIDTH-1], x[OUT_WIDTH-2:0]};
  endfunction

endpackage : BatchOut_p

// File: rtl/batch_out_fifo_mem.sv
// FifoMem: first-word-fall-through register FIFO.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset (clears storage too)
//   push, pop       - raw requests; push is refused while full unless popping,
//                     pop is ignored while empty
//   wrData          - word written on an accepted push
//   rdData          - current head (mem[rd_ptr])
//   full, empty     - occupancy flags
//   level           - occupancy, 0..DEPTH
module FifoMem #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             wr_en_c;
  logic             rd_en_c;

  // Extra pointer MSB separates the full and empty cases when low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A push into a full FIFO succeeds only when the head leaves on the same edge.
  assign rd_en_c = pop & ~empty;
  assign wr_en_c = push & (~full | rd_en_c);

  assign rdData = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = wrData;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (rd_en_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule : FifoMem

// File: rtl/batch_out_fifo.sv
// batch_out_fifo: buffers filter results onto a ready/valid stream.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in, inValid, inStrobe - filter result (offset binary), valid level, per-result pulse
//   outData, outValid     - FIFO head and its valid flag (first-word fall-through)
//   outReady              - consumer accepts the head
//   level                 - current occupancy
//   overflow, dropCnt     - sticky drop flag and saturating drop count
//   clr                   - synchronous clear of overflow/dropCnt
// The filter cannot be stalled, so a push into a full FIFO is dropped and counted.
module batch_out_fifo
  import BatchOut_p::*;
#(
  parameter int unsigned WIDTH      = OUT_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter bit          SIGNED_OUT = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in,
  input  logic                    inValid,
  input  logic                    inStrobe,
  output logic [WIDTH-1:0]        outData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        dropCnt,
  input  logic                    clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] wr_word_c;
  logic             push_c;
  logic             pop_c;
  logic             drop_c;
  logic             full_c;
  logic             empty_c;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Optional sign conversion of the stored word.
  generate
    if (!SIGNED_OUT) begin : g_pass
      assign wr_word_c = in;
    end else if (WIDTH == OUT_WIDTH) begin : g_pkg_conv
      assign wr_word_c = offset_to_signed(in);
    end else begin : g_gen_conv
      assign wr_word_c = {~in[WIDTH-1], in[WIDTH-2:0]};
    end
  endgenerate

  // Results arriving while the filter is not valid are discarded silently.
  assign push_c   = inStrobe & inValid;
  assign pop_c    = outValid & outReady;
  assign drop_c   = push_c & full_c & ~pop_c;
  assign outValid = ~empty_c;

  FifoMem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .push   (push_c),
    .pop    (pop_c),
    .wrData (wr_word_c),
    .rdData (outData),
    .full   (full_c),
    .empty  (empty_c),
    .level  (level)
  );

  // Drop bookkeeping; a clear in the same cycle as a drop takes priority.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign dropCnt  = drop_cnt_q;

endmodule : batch_out_fifo

// File: tb/tb_batch_out_fifo.sv
// Self-checking bench for batch_out_fifo (DEPTH=16, SIGNED_OUT=1, CNT_W=8).
// Reference: a queue of converted samples plus a drop flag/counter.
module tb_batch_out_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 12;
  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_s = '0;
  logic             in_valid = 1'b0;
  logic             in_strobe = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4:0]       level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic             clr = 1'b0;

  int n_tests  = 0;
  int n_failed = 0;

  int q[$];
  int m_ovf = 0;
  int m_cnt = 0;

  batch_out_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .SIGNED_OUT (1'b1),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_s),
    .inValid  (in_valid),
    .inStrobe (in_strobe),
    .outData  (out_data),
    .outValid (out_valid),
    .outReady (out_ready),
    .level    (level),
    .overflow (overflow),
    .dropCnt  (drop_cnt),
    .clr      (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference for one clock edge, evaluated on the inputs about to be sampled.
  task automatic model_edge();
    bit push, pop, drop;
    push = in_strobe && in_valid;
    pop  = (q.size() != 0) && out_ready;
    drop = push && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back((int'(in_s) + 2048) % 4096);
    if (clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".outValid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".level"},    32'(level),     32'(q.size()));
    chk({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    chk({tag, ".dropCnt"},  32'(drop_cnt),  32'(m_cnt));
    if (q.size() != 0) chk({tag, ".outData"}, 32'(out_data), 32'(q[0]));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input bit stb, input bit vld, input logic [WIDTH-1:0] d, input bit rdy);
    in_strobe = stb;
    in_valid  = vld;
    in_s      = d;
    out_ready = rdy;
  endtask

  initial begin
    logic [WIDTH-1:0] vec [3];
    vec[0] = 12'h800; vec[1] = 12'hFFF; vec[2] = 12'h000;

    // Reset state
    #1;
    chk("rst.outValid", 32'(out_valid), 32'd0);
    chk("rst.level",    32'(level),     32'd0);
    chk("rst.outData",  32'(out_data),  32'd0);
    chk("rst.overflow", 32'(overflow),  32'd0);
    chk("rst.dropCnt",  32'(drop_cnt),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sign conversion, one cycle from strobe to head, consumer always ready
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, vec[i], 1'b1);
      tick("conv");
      chk("conv.head", 32'(out_data), (i == 0) ? 32'h000 : (i == 1) ? 32'h7FF : 32'h800);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    tick("conv.drain");

    // Strobes without valid are ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 12'(i * 97), 1'b1);
      tick("novalid");
    end
    chk("novalid.level", 32'(level), 32'd0);

    // Overfill by four, then drain in order
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 12'($urandom), 1'b0);
      tick("fill");
    end
    chk("fill.level",    32'(level),    32'd16);
    chk("fill.overflow", 32'(overflow), 32'd1);
    chk("fill.dropCnt",  32'(drop_cnt), 32'd4);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, '0, 1'b1);
      tick("drain");
    end
    chk("drain.empty", 32'(out_valid), 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 12'($urandom), 1'b0);
      tick("refill");
    end
    drive(1'b1, 1'b1, 12'h123, 1'b1);
    tick("fullpp");
    chk("fullpp.level",   32'(level),    32'd16);
    chk("fullpp.dropCnt", 32'(drop_cnt), 32'd4);

    // Saturate the drop counter
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b1, 12'($urandom), 1'b0);
      tick("sat");
    end
    chk("sat.dropCnt", 32'(drop_cnt), 32'd255);
    drive(1'b1, 1'b1, 12'h456, 1'b0);
    tick("sat.more");
    chk("sat.hold", 32'(drop_cnt), 32'd255);

    // Clear keeps contents; clear beats a coincident drop
    drive(1'b0, 1'b0, '0, 1'b0);
    clr = 1'b1;
    tick("clr");
    chk("clr.overflow", 32'(overflow), 32'd0);
    chk("clr.dropCnt",  32'(drop_cnt), 32'd0);
    chk("clr.level",    32'(level),    32'd16);
    drive(1'b1, 1'b1, 12'h789, 1'b0);
    tick("clrdrop");
    chk("clrdrop.dropCnt", 32'(drop_cnt), 32'd0);
    clr = 1'b0;
    tick("afterclr");
    chk("afterclr.dropCnt",  32'(drop_cnt), 32'd1);
    chk("afterclr.overflow", 32'(overflow), 32'd1);

    // Asynchronous reset while holding seven entries
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      tick("drain2");
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 12'($urandom), 1'b0);
      tick("hold7");
    end
    chk("hold7.level", 32'(level), 32'd7);
    drive(1'b0, 1'b0, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.outValid", 32'(out_valid), 32'd0);
    chk("arst.level",    32'(level),     32'd0);
    chk("arst.outData",  32'(out_data),  32'd0);
    chk("arst.overflow", 32'(overflow),  32'd0);
    q.delete();
    m_ovf = 0;
    m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b1, 12'h0A5, 1'b0);
    tick("postrst");
    chk("postrst.head", 32'(out_data), 32'h8A5);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
            12'($urandom), 1'($urandom_range(0, 2) == 0));
      clr = ($urandom_range(0, 31) == 0);
      tick("rand");
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule : tb_batch_out_fifo
